// File: rtl/reference_sweep_buffer.sv
// rtl/reference_sweep_buffer.sv - circular I/Q reference store streaming oldest-relative sweeps
// Optional feature: define REF_BUF_CONJ_EN to output the saturated conjugate (-q).
module reference_sweep_buffer #(
  parameter int I_BITS      = 12,
  parameter int Q_BITS      = 12,
  parameter int BUFFER_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_wr_tvalid,
  output logic                     s_axis_wr_tready,
  input  logic [I_BITS+Q_BITS-1:0] s_axis_wr_tdata,
  input  logic                     m_axis_index_tvalid,
  input  logic [BUFFER_BITS-1:0]   m_axis_index_tdata,
  input  logic [BUFFER_BITS:0]     m_axis_index_tlen,
  output logic                     s_axis_data_tready,
  output logic [I_BITS-1:0]        i,
  output logic [Q_BITS-1:0]        q,
  output logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tlast,
  input  logic                     m_axis_tready,
  output logic                     loaded
);

  localparam int W = I_BITS + Q_BITS;
  localparam logic [BUFFER_BITS:0] DEPTH_L = (BUFFER_BITS+1)'(1) << BUFFER_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]             state;
  logic [BUFFER_BITS-1:0] wr_ptr;
  logic [BUFFER_BITS-1:0] base;
  logic [BUFFER_BITS-1:0] rd_addr;
  logic [BUFFER_BITS:0]   fill_cnt;
  logic [BUFFER_BITS:0]   sweep_len;
  logic [BUFFER_BITS:0]   issued;
  logic [BUFFER_BITS:0]   req_len;

  logic [W-1:0] mem [2**BUFFER_BITS];
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rd_last;

  // Output stage: head register drives the ports, skid holds the read that was in flight during a stall.
  logic [1:0]   out_cnt;
  logic [W:0]   head;
  logic [W:0]   skid;
  logic [W:0]   push_entry;
  logic [Q_BITS-1:0] q_stage;

  logic       wr_fire;
  logic       idx_fire;
  logic       pop;
  logic [2:0] occ;
  logic       space;
  logic       issue;
  logic       last_issue;

  assign s_axis_wr_tready   = (state == ST_IDLE) && !m_axis_index_tvalid;
  assign s_axis_data_tready = (state == ST_IDLE) && loaded;

  assign wr_fire  = s_axis_wr_tvalid && s_axis_wr_tready;
  assign idx_fire = m_axis_index_tvalid && s_axis_data_tready;

  assign s_axis_data_tvalid = (out_cnt != 2'd0);
  assign s_axis_data_tlast  = head[W];
  assign i                  = head[Q_BITS +: I_BITS];
  assign q                  = head[Q_BITS-1:0];

  assign pop        = s_axis_data_tvalid && m_axis_tready;
  assign occ        = {1'b0, out_cnt} + {2'b00, rd_valid};
  assign space      = occ < (3'd2 + {2'b00, pop});
  assign issue      = (state == ST_SWEEP) && space;
  assign last_issue = issue && (issued == sweep_len - 1'b1);
  assign rd_addr    = base + issued[BUFFER_BITS-1:0];

  always_comb begin
    req_len = m_axis_index_tlen;
    if (m_axis_index_tlen == '0)
      req_len = (BUFFER_BITS+1)'(1);
    else if (m_axis_index_tlen > DEPTH_L)
      req_len = DEPTH_L;
  end

`ifdef REF_BUF_CONJ_EN
  localparam logic [Q_BITS-1:0] Q_MIN = {1'b1, {(Q_BITS-1){1'b0}}};
  localparam logic [Q_BITS-1:0] Q_MAX = {1'b0, {(Q_BITS-1){1'b1}}};
  assign q_stage = (rd_data[Q_BITS-1:0] == Q_MIN) ? Q_MAX : (~rd_data[Q_BITS-1:0] + 1'b1);
`else
  assign q_stage = rd_data[Q_BITS-1:0];
`endif

  assign push_entry = {rd_last, rd_data[W-1:Q_BITS], q_stage};

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_ptr] <= s_axis_wr_tdata;
    if (issue)
      rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      loaded   <= 1'b0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!loaded) begin
        fill_cnt <= fill_cnt + 1'b1;
        if (fill_cnt == DEPTH_L - 1'b1)
          loaded <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      base      <= '0;
      sweep_len <= '0;
      issued    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (idx_fire) begin
            base      <= wr_ptr + m_axis_index_tdata;
            sweep_len <= req_len;
            issued    <= '0;
            state     <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (issue)
            issued <= issued + 1'b1;
          if (last_issue)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && head[W])
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= issue;
      rd_last  <= last_issue;
    end
  end

  // Issue control guarantees a read never lands while both entries are full and unpopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= 2'd0;
      head    <= '0;
      skid    <= '0;
    end else begin
      case (out_cnt)
        2'd0: begin
          if (rd_valid) begin
            head    <= push_entry;
            out_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && rd_valid) begin
            head <= push_entry;
          end else if (pop) begin
            out_cnt <= 2'd0;
          end else if (rd_valid) begin
            skid    <= push_entry;
            out_cnt <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head <= skid;
            if (rd_valid)
              skid <= push_entry;
            else
              out_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reference_sweep_buffer.sv
// tb/tb_reference_sweep_buffer.sv - directed bench with a queue-based sweep model
module tb_reference_sweep_buffer;

  localparam int IB = 8;
  localparam int QB = 8;
  localparam int BB = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic wr_tvalid;
  logic wr_tready;
  logic [IB+QB-1:0] wr_tdata;
  logic idx_tvalid;
  logic [BB-1:0] idx_tdata;
  logic [BB:0] idx_tlen;
  logic data_tready;
  logic [IB-1:0] out_i;
  logic [QB-1:0] out_q;
  logic out_tvalid;
  logic out_tlast;
  logic m_tready;
  logic loaded;

  always #5 clk = ~clk;

  reference_sweep_buffer #(.I_BITS(IB), .Q_BITS(QB), .BUFFER_BITS(BB)) dut (
    .clk(clk), .rst(rst),
    .s_axis_wr_tvalid(wr_tvalid), .s_axis_wr_tready(wr_tready), .s_axis_wr_tdata(wr_tdata),
    .m_axis_index_tvalid(idx_tvalid), .m_axis_index_tdata(idx_tdata), .m_axis_index_tlen(idx_tlen),
    .s_axis_data_tready(data_tready), .i(out_i), .q(out_q),
    .s_axis_data_tvalid(out_tvalid), .s_axis_data_tlast(out_tlast),
    .m_axis_tready(m_tready), .loaded(loaded)
  );

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] q;
    logic       last;
  } samp_t;

  logic [15:0] mem_m [DEPTH];
  int    wr_cnt;
  int    wptr;
  bit    busy;
  int    since_acc;
  bit    seen_first;
  int    first_lat;
  samp_t expq[$];
  logic [7:0] got_i[$];
  logic [7:0] got_q[$];
  bit    p_valid, p_ready, p_last;
  logic [7:0] p_i, p_q;
  int    vecs;
  int    miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] conj_m(input logic [7:0] v);
`ifdef REF_BUF_CONJ_EN
    if (v == 8'h80) return 8'h7f;
    return 8'(-v);
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    wr_cnt = 0; wptr = 0; busy = 0; since_acc = 0; seen_first = 0;
    expq.delete();
    p_valid = 0; p_ready = 0; p_last = 0; p_i = 0; p_q = 0;
  endtask

  task automatic compare();
    bit busy_now;
    bit exp_loaded;
    samp_t e;
    int base;
    int n;
    busy_now   = busy;
    exp_loaded = (wr_cnt >= DEPTH);
    if (busy_now) since_acc++;
    chk("loaded", loaded, exp_loaded);
    chk("wr_tready", wr_tready, !busy_now && !idx_tvalid);
    chk("data_tready", data_tready, !busy_now && exp_loaded);
    if (busy_now && !seen_first && since_acc <= 3)
      chk("first_valid_timing", out_tvalid, since_acc == 3);
    if (p_valid && p_ready && !p_last)
      chk("no_bubble", out_tvalid, 1'b1);
    if (p_valid && !p_ready)
      chk("stall_hold", {out_tvalid, out_i, out_q, out_tlast}, {1'b1, p_i, p_q, p_last});
    if (out_tvalid) begin
      if (expq.size() == 0) begin
        chk("spurious_tvalid", out_tvalid, 1'b0);
      end else begin
        e = expq[0];
        chk("sample", {out_i, out_q, out_tlast}, {e.i, e.q, e.last});
        if (!seen_first) begin
          seen_first = 1;
          first_lat  = since_acc - 1;
        end
        if (m_tready) begin
          void'(expq.pop_front());
          got_i.push_back(out_i);
          got_q.push_back(out_q);
          if (e.last) busy = 0;
        end
      end
    end
    if (wr_tvalid && !busy_now && !idx_tvalid) begin
      mem_m[wptr] = wr_tdata;
      wptr = (wptr + 1) % DEPTH;
      wr_cnt++;
    end
    if (idx_tvalid && !busy_now && exp_loaded) begin
      base = (wptr + int'(idx_tdata)) % DEPTH;
      n = (idx_tlen == 0) ? 1 : ((int'(idx_tlen) > DEPTH) ? DEPTH : int'(idx_tlen));
      for (int k = 0; k < n; k++) begin
        e.i    = mem_m[(base + k) % DEPTH][15:8];
        e.q    = conj_m(mem_m[(base + k) % DEPTH][7:0]);
        e.last = (k == n - 1);
        expq.push_back(e);
      end
      busy = 1; since_acc = 0; seen_first = 0;
    end
    p_valid = out_tvalid; p_ready = m_tready;
    p_i = out_i; p_q = out_q; p_last = out_tlast;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic write_s(input logic [7:0] iv, input logic [7:0] qv);
    wr_tvalid = 1; wr_tdata = {iv, qv};
    step();
    wr_tvalid = 0;
  endtask

  task automatic load16();
    for (int k = 0; k < DEPTH; k++) write_s(8'(k), 8'(-k));
  endtask

  task automatic sweep(input int idx, input int len, input bit toggle);
    int cyc;
    got_i.delete(); got_q.delete();
    idx_tvalid = 1; idx_tdata = BB'(idx); idx_tlen = (BB+1)'(len); m_tready = 1;
    step();
    idx_tvalid = 0;
    cyc = 0;
    while (busy && cyc < 200) begin
      m_tready = toggle ? (cyc % 3 == 0) : 1'b1;
      step();
      cyc++;
    end
    m_tready = 1;
    if (busy) begin
      vecs++; miss++;
      $display("FAIL sweep_timeout: got busy expected done at %0t", $time);
      model_reset();
    end
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int cyc;
    vecs = 0; miss = 0; first_lat = -1;
    wr_tvalid = 0; wr_tdata = 0; idx_tvalid = 0; idx_tdata = 0; idx_tlen = 0; m_tready = 1;
    rst = 1;
    model_reset();
    #12;
    chk("reset_outputs", {out_tvalid, out_tlast, out_i, out_q, data_tready, loaded}, 0);
    @(posedge clk); #1; rst = 0;

    // 16 loads, index 3 len 4 with tready high
    for (int k = 0; k < 15; k++) write_s(8'(k), 8'(-k));
    chk("loaded_before_16th", loaded, 1'b0);
    write_s(8'd15, 8'(-15));
    chk("loaded_after_16th", loaded, 1'b1);
    sweep(3, 4, 0);
    chk("sweepA_count", got_i.size(), 4);
    chk("sweepA_i", {got_i[0], got_i[1], got_i[2], got_i[3]}, 32'h03040506);
    chk("sweepA_q0", got_q[0], conj_m(8'hfd));
    chk("sweepA_latency", first_lat, 2);

    // 20 total writes: oldest is now sample 4
    for (int k = 16; k < 20; k++) write_s(8'(k), 8'(-k));
    sweep(0, 16, 0);
    chk("sweepB_count", got_i.size(), 16);
    chk("sweepB_first", got_i[0], 8'd4);
    chk("sweepB_last", got_i[15], 8'd19);

    // wrap with backpressure
    do_reset();
    load16();
    sweep(14, 5, 1);
    chk("sweepC_count", got_i.size(), 5);
    chk("sweepC_i", {got_i[0], got_i[1], got_i[2], got_i[3], got_i[4]}, 40'h0e0f000102);

    // index before loaded, then same-cycle write+index
    do_reset();
    for (int k = 0; k < 8; k++) write_s(8'(k), 8'(-k));
    idx_tvalid = 1; idx_tdata = 0; idx_tlen = 1;
    for (int k = 0; k < 3; k++) step();
    idx_tvalid = 0;
    chk("unloaded_data_tready", data_tready, 1'b0);
    for (int k = 8; k < 16; k++) write_s(8'(k), 8'(-k));
    got_i.delete(); got_q.delete();
    wr_tvalid = 1; wr_tdata = {8'd100, 8'd50};
    idx_tvalid = 1; idx_tdata = 0; idx_tlen = 1;
    step();
    idx_tvalid = 0;
    chk("same_cycle_write_stalled", wr_cnt, 16);
    cyc = 0;
    while ((busy || wr_cnt == 16) && cyc < 50) begin
      step();
      cyc++;
    end
    wr_tvalid = 0;
    chk("same_cycle_write_later", wr_cnt, 17);
    chk("same_cycle_index_sample", got_i[0], 8'd0);
    sweep(15, 1, 0);
    chk("newest_sample", got_i[0], 8'd100);

    // reset during the 3rd sample of a len-8 sweep
    do_reset();
    load16();
    got_i.delete(); got_q.delete();
    idx_tvalid = 1; idx_tdata = 0; idx_tlen = 8;
    step();
    idx_tvalid = 0;
    cyc = 0;
    while (got_i.size() < 2 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("third_sample_present", out_i, 8'd2);
    #3 rst = 1;
    #1;
    chk("async_reset_outputs", {out_tvalid, loaded, out_tlast, out_i}, 0);
    model_reset();
    @(posedge clk); #1; rst = 0;
    step();
    chk("post_reset_data_tready", data_tready, 1'b0);

    // reload with conjugate corner values, then tlen 0 and clamp
    for (int k = 0; k < 14; k++) write_s(8'(k), 8'(-k));
    write_s(8'd14, 8'h80);
    write_s(8'd15, 8'h05);
    sweep(14, 2, 0);
`ifdef REF_BUF_CONJ_EN
    chk("conj_min", got_q[0], 8'h7f);
    chk("conj_5", got_q[1], 8'hfb);
`else
    chk("pass_min", got_q[0], 8'h80);
    chk("pass_5", got_q[1], 8'h05);
`endif
    sweep(0, 0, 0);
    chk("len0_count", got_i.size(), 1);
    sweep(2, 31, 0);
    chk("clamp_count", got_i.size(), 16);
    chk("clamp_last", got_i[15], 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
